// File: rtl/ysyx_axi_arb_pkg.sv
// Shared types for the two-master AXI4 arbiter: FSM state encodings,
// channel payload structs and AXI response codes.
package ysyx_axi_arb_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_ID_W   = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [1:0] rd_state_t;
  localparam rd_state_t R_IDLE = 2'd0;
  localparam rd_state_t R_ADDR = 2'd1;
  localparam rd_state_t R_DATA = 2'd2;

  typedef logic [1:0] wr_state_t;
  localparam wr_state_t W_IDLE = 2'd0;
  localparam wr_state_t W_XFER = 2'd1;
  localparam wr_state_t W_RESP = 2'd2;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_ID_W-1:0]   id;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ax_chan_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
  } w_chan_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [AXI_ID_W-1:0]   id;
  } r_chan_t;

  typedef struct packed {
    logic [1:0]          resp;
    logic [AXI_ID_W-1:0] id;
  } b_chan_t;

endpackage

// File: rtl/ysyx_rr_arb2.sv
// Two-way round-robin grant; the pointer moves past the finishing owner on adv.
module ysyx_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       adv,
  input  logic       owner,
  output logic       gnt
);

  logic ptr;

  // Lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    gnt = (req == 2'b11) ? ptr : req[1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (adv) begin
      ptr <= ~owner;
    end
  end

endmodule

// File: rtl/ysyx_axi_master_arbiter.sv
// Shares io_master between two upstream AXI4 masters; read and write paths
// are arbitrated independently with one outstanding transaction each.
module ysyx_axi_master_arbiter
  import ysyx_axi_arb_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int ID_W   = AXI_ID_W
) (
  input  logic                clock,
  input  logic                reset,
  // upstream 0
  input  logic                s0_arvalid,
  output logic                s0_arready,
  input  logic [ADDR_W-1:0]   s0_araddr,
  input  logic [ID_W-1:0]     s0_arid,
  input  logic [7:0]          s0_arlen,
  input  logic [2:0]          s0_arsize,
  input  logic [1:0]          s0_arburst,
  output logic                s0_rvalid,
  input  logic                s0_rready,
  output logic [DATA_W-1:0]   s0_rdata,
  output logic [1:0]          s0_rresp,
  output logic                s0_rlast,
  output logic [ID_W-1:0]     s0_rid,
  input  logic                s0_awvalid,
  output logic                s0_awready,
  input  logic [ADDR_W-1:0]   s0_awaddr,
  input  logic [ID_W-1:0]     s0_awid,
  input  logic [7:0]          s0_awlen,
  input  logic [2:0]          s0_awsize,
  input  logic [1:0]          s0_awburst,
  input  logic                s0_wvalid,
  output logic                s0_wready,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  input  logic                s0_wlast,
  output logic                s0_bvalid,
  input  logic                s0_bready,
  output logic [1:0]          s0_bresp,
  output logic [ID_W-1:0]     s0_bid,
  // upstream 1
  input  logic                s1_arvalid,
  output logic                s1_arready,
  input  logic [ADDR_W-1:0]   s1_araddr,
  input  logic [ID_W-1:0]     s1_arid,
  input  logic [7:0]          s1_arlen,
  input  logic [2:0]          s1_arsize,
  input  logic [1:0]          s1_arburst,
  output logic                s1_rvalid,
  input  logic                s1_rready,
  output logic [DATA_W-1:0]   s1_rdata,
  output logic [1:0]          s1_rresp,
  output logic                s1_rlast,
  output logic [ID_W-1:0]     s1_rid,
  input  logic                s1_awvalid,
  output logic                s1_awready,
  input  logic [ADDR_W-1:0]   s1_awaddr,
  input  logic [ID_W-1:0]     s1_awid,
  input  logic [7:0]          s1_awlen,
  input  logic [2:0]          s1_awsize,
  input  logic [1:0]          s1_awburst,
  input  logic                s1_wvalid,
  output logic                s1_wready,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  input  logic                s1_wlast,
  output logic                s1_bvalid,
  input  logic                s1_bready,
  output logic [1:0]          s1_bresp,
  output logic [ID_W-1:0]     s1_bid,
  // downstream
  output logic                io_master_arvalid,
  input  logic                io_master_arready,
  output logic [ADDR_W-1:0]   io_master_araddr,
  output logic [ID_W-1:0]     io_master_arid,
  output logic [7:0]          io_master_arlen,
  output logic [2:0]          io_master_arsize,
  output logic [1:0]          io_master_arburst,
  input  logic                io_master_rvalid,
  output logic                io_master_rready,
  input  logic [DATA_W-1:0]   io_master_rdata,
  input  logic [1:0]          io_master_rresp,
  input  logic                io_master_rlast,
  input  logic [ID_W-1:0]     io_master_rid,
  output logic                io_master_awvalid,
  input  logic                io_master_awready,
  output logic [ADDR_W-1:0]   io_master_awaddr,
  output logic [ID_W-1:0]     io_master_awid,
  output logic [7:0]          io_master_awlen,
  output logic [2:0]          io_master_awsize,
  output logic [1:0]          io_master_awburst,
  output logic                io_master_wvalid,
  input  logic                io_master_wready,
  output logic [DATA_W-1:0]   io_master_wdata,
  output logic [DATA_W/8-1:0] io_master_wstrb,
  output logic                io_master_wlast,
  input  logic                io_master_bvalid,
  output logic                io_master_bready,
  input  logic [1:0]          io_master_bresp,
  input  logic [ID_W-1:0]     io_master_bid
);

  // ---------------- read path ----------------
  rd_state_t rd_state;
  logic      rgnt;
  logic      rd_arb_gnt;
  logic      rd_in_addr;
  logic      rd_in_data;
  logic      ar_hs;
  logic      r_last_hs;
  logic      rd_adv;
  logic [1:0] s_arvalid;
  logic [1:0] s_rready;
  ax_chan_t  s_ar [2];
  ax_chan_t  ar_sel;
  r_chan_t   r_bus;

  assign s_arvalid = {s1_arvalid, s0_arvalid};
  assign s_rready  = {s1_rready, s0_rready};
  assign s_ar[0]   = {s0_araddr, s0_arid, s0_arlen, s0_arsize, s0_arburst};
  assign s_ar[1]   = {s1_araddr, s1_arid, s1_arlen, s1_arsize, s1_arburst};
  assign ar_sel    = s_ar[rgnt];
  assign r_bus     = {io_master_rdata, io_master_rresp, io_master_rlast, io_master_rid};

  assign rd_in_addr = (rd_state == R_ADDR);
  assign rd_in_data = (rd_state == R_DATA);
  assign ar_hs      = io_master_arvalid & io_master_arready;
  assign r_last_hs  = io_master_rvalid & io_master_rready & io_master_rlast;
  assign rd_adv     = rd_in_data & r_last_hs;

  ysyx_rr_arb2 u_rd_arb (
    .clock (clock),
    .reset (reset),
    .req   (s_arvalid),
    .adv   (rd_adv),
    .owner (rgnt),
    .gnt   (rd_arb_gnt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state <= R_IDLE;
      rgnt     <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: if (|s_arvalid) begin
          rgnt     <= rd_arb_gnt;
          rd_state <= R_ADDR;
        end
        R_ADDR: if (ar_hs) rd_state <= R_DATA;
        R_DATA: if (r_last_hs) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Forwarding is purely combinational once granted; IDLE never forwards.
  assign io_master_arvalid = rd_in_addr & s_arvalid[rgnt];
  assign io_master_araddr  = ar_sel.addr;
  assign io_master_arid    = ar_sel.id;
  assign io_master_arlen   = ar_sel.len;
  assign io_master_arsize  = ar_sel.size;
  assign io_master_arburst = ar_sel.burst;
  assign s0_arready        = rd_in_addr & ~rgnt & io_master_arready;
  assign s1_arready        = rd_in_addr &  rgnt & io_master_arready;

  assign io_master_rready  = rd_in_data & s_rready[rgnt];
  assign s0_rvalid         = rd_in_data & ~rgnt & io_master_rvalid;
  assign s1_rvalid         = rd_in_data &  rgnt & io_master_rvalid;
  assign s0_rdata          = r_bus.data;
  assign s1_rdata          = r_bus.data;
  assign s0_rresp          = r_bus.resp;
  assign s1_rresp          = r_bus.resp;
  assign s0_rlast          = r_bus.last;
  assign s1_rlast          = r_bus.last;
  assign s0_rid            = r_bus.id;
  assign s1_rid            = r_bus.id;

  // ---------------- write path ----------------
  wr_state_t wr_state;
  logic      wgnt;
  logic      wr_arb_gnt;
  logic      aw_done;
  logic      w_done;
  logic      wr_in_xfer;
  logic      wr_in_resp;
  logic      aw_hs;
  logic      w_last_hs;
  logic      b_hs;
  logic      wr_adv;
  logic [1:0] s_awvalid;
  logic [1:0] s_wvalid;
  logic [1:0] s_bready;
  ax_chan_t  s_aw [2];
  ax_chan_t  aw_sel;
  w_chan_t   s_w [2];
  w_chan_t   w_sel;
  b_chan_t   b_bus;

  assign s_awvalid = {s1_awvalid, s0_awvalid};
  assign s_wvalid  = {s1_wvalid, s0_wvalid};
  assign s_bready  = {s1_bready, s0_bready};
  assign s_aw[0]   = {s0_awaddr, s0_awid, s0_awlen, s0_awsize, s0_awburst};
  assign s_aw[1]   = {s1_awaddr, s1_awid, s1_awlen, s1_awsize, s1_awburst};
  assign s_w[0]    = {s0_wdata, s0_wstrb, s0_wlast};
  assign s_w[1]    = {s1_wdata, s1_wstrb, s1_wlast};
  assign aw_sel    = s_aw[wgnt];
  assign w_sel     = s_w[wgnt];
  assign b_bus     = {io_master_bresp, io_master_bid};

  assign wr_in_xfer = (wr_state == W_XFER);
  assign wr_in_resp = (wr_state == W_RESP);
  assign aw_hs      = io_master_awvalid & io_master_awready;
  assign w_last_hs  = io_master_wvalid & io_master_wready & io_master_wlast;
  assign b_hs       = io_master_bvalid & io_master_bready;
  assign wr_adv     = wr_in_resp & b_hs;

  ysyx_rr_arb2 u_wr_arb (
    .clock (clock),
    .reset (reset),
    .req   (s_awvalid),
    .adv   (wr_adv),
    .owner (wgnt),
    .gnt   (wr_arb_gnt)
  );

  // AW and W run concurrently; each channel closes independently via its flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state <= W_IDLE;
      wgnt     <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: if (|s_awvalid) begin
          wgnt     <= wr_arb_gnt;
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
          wr_state <= W_XFER;
        end
        W_XFER: begin
          aw_done <= aw_done | aw_hs;
          w_done  <= w_done | w_last_hs;
          if ((aw_done | aw_hs) && (w_done | w_last_hs)) wr_state <= W_RESP;
        end
        W_RESP: if (b_hs) begin
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
          wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  assign io_master_awvalid = wr_in_xfer & ~aw_done & s_awvalid[wgnt];
  assign io_master_awaddr  = aw_sel.addr;
  assign io_master_awid    = aw_sel.id;
  assign io_master_awlen   = aw_sel.len;
  assign io_master_awsize  = aw_sel.size;
  assign io_master_awburst = aw_sel.burst;
  assign s0_awready        = wr_in_xfer & ~aw_done & ~wgnt & io_master_awready;
  assign s1_awready        = wr_in_xfer & ~aw_done &  wgnt & io_master_awready;

  assign io_master_wvalid  = wr_in_xfer & ~w_done & s_wvalid[wgnt];
  assign io_master_wdata   = w_sel.data;
  assign io_master_wstrb   = w_sel.strb;
  assign io_master_wlast   = w_sel.last;
  assign s0_wready         = wr_in_xfer & ~w_done & ~wgnt & io_master_wready;
  assign s1_wready         = wr_in_xfer & ~w_done &  wgnt & io_master_wready;

  assign io_master_bready  = wr_in_resp & s_bready[wgnt];
  assign s0_bvalid         = wr_in_resp & ~wgnt & io_master_bvalid;
  assign s1_bvalid         = wr_in_resp &  wgnt & io_master_bvalid;
  assign s0_bresp          = b_bus.resp;
  assign s1_bresp          = b_bus.resp;
  assign s0_bid            = b_bus.id;
  assign s1_bid            = b_bus.id;

endmodule
